// File: rtl/round_pack_sched_pkg.sv
// Shared definitions for round_pack_sched.
// Contents: the scheduler FSM state encoding, the default result returned when a
// job is aborted by the watchdog (quiet NaN), and the exception flag bit values
// reported by the roundAndPackFloat64 engine.
package round_pack_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [63:0] NAN_RESULT_DEFAULT = 64'h7FF8000000000000;

    localparam logic [31:0] FLAG_INEXACT   = 32'd1;
    localparam logic [31:0] FLAG_UNDERFLOW = 32'd4;
    localparam logic [31:0] FLAG_OVERFLOW  = 32'd8;

endpackage

// File: rtl/round_pack_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a last-grant pointer.
// Ports:
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   req[1:0]       : request vector (bit N = requester N valid)
//   upd            : grant was taken this cycle, advance the pointer
//   gnt[1:0]       : one-hot grant (all zero when nothing requests)
//   gnt_id         : index of the granted requester
// The pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_r;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                gnt_id = ~last_r;
                gnt    = last_r ? 2'b01 : 2'b10;
            end
            default: begin
                gnt    = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

    // Last-grant pointer, advanced only when a grant is actually consumed.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            last_r <= 1'b1;
        end else if (upd) begin
            last_r <= gnt_id;
        end
    end

endmodule

// File: rtl/round_pack_sched.sv
// round_pack_sched: schedules two requesters onto one external
// roundAndPackFloat64 engine (ap_ctrl_hs handshake), with per-requester sticky
// exception flags and a per-job watchdog.
// Ports:
//   ap_clk, ap_rst                      : clock, asynchronous active-high reset
//   reqN_valid/ready, reqN_sign/exp/sig : request channel N (N = 0, 1)
//   respN_valid/ready                   : response channel N
//   resp_data, resp_err                 : shared response payload, watchdog-abort marker
//   flagN, flag_clr                     : sticky engine flags per requester, clear
//   wdog_err                            : sticky "a job was aborted" flag
//   eng_start/done, eng_z*, eng_flag_*  : engine interface
//   eng_return                          : engine result
module round_pack_sched
    import round_pack_sched_pkg::*;
#(
    parameter int unsigned WDOG_CYC   = 16,
    parameter logic [63:0] NAN_RESULT = NAN_RESULT_DEFAULT
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sign,
    input  logic [11:0] req0_exp,
    input  logic [63:0] req0_sig,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sign,
    input  logic [11:0] req1_exp,
    input  logic [63:0] req1_sig,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [31:0] flag0,
    output logic [31:0] flag1,
    input  logic [1:0]  flag_clr,
    output logic        wdog_err,
    output logic        eng_start,
    input  logic        eng_done,
    output logic        eng_zSign,
    output logic [11:0] eng_zExp,
    output logic [63:0] eng_zSig,
    output logic [31:0] eng_flag_i,
    input  logic [31:0] eng_flag_o,
    input  logic        eng_flag_o_vld,
    input  logic [63:0] eng_return
);

    localparam int unsigned CNT_W = $clog2(WDOG_CYC + 1);

    state_t             state_r, state_nxt_s;
    logic [1:0]         gnt_s;
    logic               gnt_id_s;
    logic               accept_s, done_s, wdog_hit_s, resp_hs_s;
    logic               upd0_s, upd1_s;
    logic               act_id_r;
    logic               zsign_r;
    logic [11:0]        zexp_r;
    logic [63:0]        zsig_r;
    logic [63:0]        res_r;
    logic               resp_err_r, wdog_err_r, eng_start_r;
    logic               resp0_valid_r, resp1_valid_r;
    logic [31:0]        flag0_r, flag1_r;
    logic [CNT_W-1:0]   run_cnt_r;

    rr_arb2 u_arb (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .req    ({req1_valid, req0_valid}),
        .upd    (accept_s),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    // Ready is offered only while idle; held low during reset so no handshake can appear.
    assign req0_ready = (state_r == ST_IDLE) & gnt_s[0] & ~ap_rst;
    assign req1_ready = (state_r == ST_IDLE) & gnt_s[1] & ~ap_rst;
    assign accept_s   = (state_r == ST_IDLE) & (|gnt_s);

    // Engine done is only meaningful while we are driving start; an idle done is ignored.
    assign done_s     = (state_r == ST_RUN) & eng_start_r & eng_done;
    assign wdog_hit_s = (state_r == ST_RUN) & ~done_s & (run_cnt_r == CNT_W'(WDOG_CYC));
    assign resp_hs_s  = (state_r == ST_RESP) &
                        ((resp0_valid_r & resp0_ready) | (resp1_valid_r & resp1_ready));

    // A flag update from the engine targets only the active requester's register.
    assign upd0_s = (state_r == ST_RUN) & eng_flag_o_vld & (act_id_r == 1'b0);
    assign upd1_s = (state_r == ST_RUN) & eng_flag_o_vld & (act_id_r == 1'b1);

    assign eng_start   = eng_start_r;
    assign eng_zSign   = zsign_r;
    assign eng_zExp    = zexp_r;
    assign eng_zSig    = zsig_r;
    assign eng_flag_i  = act_id_r ? flag1_r : flag0_r;
    assign resp0_valid = resp0_valid_r;
    assign resp1_valid = resp1_valid_r;
    assign resp_data   = res_r;
    assign resp_err    = resp_err_r;
    assign flag0       = flag0_r;
    assign flag1       = flag1_r;
    assign wdog_err    = wdog_err_r;

    // FSM state register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (done_s || wdog_hit_s) state_nxt_s = ST_RESP;
                else                      state_nxt_s = ST_RUN;
            end
            ST_RESP: begin
                if (resp_hs_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Job datapath: operand capture, engine start, run counter, result and response flags.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            act_id_r      <= 1'b0;
            zsign_r       <= 1'b0;
            zexp_r        <= 12'd0;
            zsig_r        <= 64'd0;
            res_r         <= 64'd0;
            resp_err_r    <= 1'b0;
            wdog_err_r    <= 1'b0;
            eng_start_r   <= 1'b0;
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            run_cnt_r     <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            act_id_r    <= gnt_id_s;
            zsign_r     <= gnt_id_s ? req1_sign : req0_sign;
            zexp_r      <= gnt_id_s ? req1_exp  : req0_exp;
            zsig_r      <= gnt_id_s ? req1_sig  : req0_sig;
            eng_start_r <= 1'b1;
            run_cnt_r   <= CNT_W'(1'b1);
        end else if (done_s) begin
            res_r         <= eng_return;
            eng_start_r   <= 1'b0;
            resp0_valid_r <= ~act_id_r;
            resp1_valid_r <= act_id_r;
        end else if (wdog_hit_s) begin
            res_r         <= NAN_RESULT;
            resp_err_r    <= 1'b1;
            wdog_err_r    <= 1'b1;
            eng_start_r   <= 1'b0;
            resp0_valid_r <= ~act_id_r;
            resp1_valid_r <= act_id_r;
        end else if (state_r == ST_RUN) begin
            run_cnt_r <= run_cnt_r + CNT_W'(1'b1);
        end else if (resp_hs_s) begin
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            resp_err_r    <= 1'b0;
        end
    end

    // Sticky flags: an engine update beats a same-cycle clear of the same register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            flag0_r <= 32'd0;
            flag1_r <= 32'd0;
        end else begin
            if (upd0_s)           flag0_r <= eng_flag_o;
            else if (flag_clr[0]) flag0_r <= 32'd0;
            if (upd1_s)           flag1_r <= eng_flag_o;
            else if (flag_clr[1]) flag1_r <= 32'd0;
        end
    end

endmodule

// File: tb/tb_round_pack_sched.sv
// Self-checking bench for round_pack_sched. The bench plays the engine and
// both requesters; a small behavioural model (grant pointer, flag registers,
// watchdog flag) predicts every observed value.
module tb_round_pack_sched;
    import round_pack_sched_pkg::*;

    localparam int          WDOG   = 16;
    localparam int          PERIOD = 10;
    localparam logic [63:0] NANV   = 64'h7FF8000000000000;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        req0_valid, req0_ready, req0_sign;
    logic [11:0] req0_exp;
    logic [63:0] req0_sig;
    logic        req1_valid, req1_ready, req1_sign;
    logic [11:0] req1_exp;
    logic [63:0] req1_sig;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [63:0] resp_data;
    logic        resp_err, wdog_err;
    logic [31:0] flag0, flag1;
    logic [1:0]  flag_clr;
    logic        eng_start, eng_done, eng_zSign;
    logic [11:0] eng_zExp;
    logic [63:0] eng_zSig;
    logic [31:0] eng_flag_i, eng_flag_o;
    logic        eng_flag_o_vld;
    logic [63:0] eng_return;

    round_pack_sched #(.WDOG_CYC(WDOG), .NAN_RESULT(NANV)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sign(req0_sign),
        .req0_exp(req0_exp), .req0_sig(req0_sig),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sign(req1_sign),
        .req1_exp(req1_exp), .req1_sig(req1_sig),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .flag0(flag0), .flag1(flag1), .flag_clr(flag_clr), .wdog_err(wdog_err),
        .eng_start(eng_start), .eng_done(eng_done),
        .eng_zSign(eng_zSign), .eng_zExp(eng_zExp), .eng_zSig(eng_zSig),
        .eng_flag_i(eng_flag_i), .eng_flag_o(eng_flag_o), .eng_flag_o_vld(eng_flag_o_vld),
        .eng_return(eng_return)
    );

    always #(PERIOD/2) ap_clk = ~ap_clk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_flag [2];
    logic        m_wdog;
    int          m_last;
    time         last_t;
    bit          have_last;

    // per-requester operands for the next job
    logic        op_sign [2];
    logic [11:0] op_exp  [2];
    logic [63:0] op_sig  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic model_reset();
        m_flag[0] = 32'd0;
        m_flag[1] = 32'd0;
        m_wdog    = 1'b0;
        m_last    = 1;
        have_last = 1'b0;
        last_t    = 0;
    endtask

    task automatic rand_ops();
        for (int n = 0; n < 2; n++) begin
            op_sign[n] = 1'($urandom_range(0, 1));
            op_exp[n]  = 12'($urandom);
            op_sig[n]  = {$urandom, $urandom};
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_eng_start"}, eng_start, 1'b0);
        chk({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
        chk({tag, "_resp_valid"}, {resp1_valid, resp0_valid}, 2'b00);
        chk({tag, "_resp_data"}, resp_data, 64'd0);
        chk({tag, "_errs"}, {resp_err, wdog_err}, 2'b00);
        chk({tag, "_flags"}, {flag1, flag0}, 64'd0);
    endtask

    // One full job: arbitration, RUN phase with engine behaviour, response.
    // lat = engine done cycle within RUN (beyond WDOG means never), fcyc/ccyc =
    // RUN cycle of a flag update / flag clear (0 = none), hold = RESP stall cycles.
    task automatic run_job(input logic [1:0] vmask, input int lat, input logic [63:0] ret,
                           input int fcyc, input logic [31:0] fval, input int ccyc,
                           input logic [1:0] cmask, input int hold);
        int          win;
        bit          aborted;
        logic [63:0] exp_data;
        req0_sign = op_sign[0]; req0_exp = op_exp[0]; req0_sig = op_sig[0];
        req1_sign = op_sign[1]; req1_exp = op_exp[1]; req1_sig = op_sig[1];
        req0_valid = vmask[0];
        req1_valid = vmask[1];
        #1;
        win = (vmask == 2'b11) ? (1 - m_last) : (vmask[1] ? 1 : 0);
        chk("req_ready", {req1_ready, req0_ready}, (win == 1) ? 2'b10 : 2'b01);
        @(posedge ap_clk);
        if (have_last) chk("accept_gap", 64'(($time - last_t) >= 5 * PERIOD), 1'b1);
        last_t    = $time;
        have_last = 1'b1;
        m_last    = win;
        #1;
        // requesters may drop or keep valid while busy; the job is already owned
        req0_valid = vmask[0] & 1'($urandom_range(0, 1));
        req1_valid = vmask[1] & 1'($urandom_range(0, 1));
        for (int c = 1; c <= WDOG; c++) begin
            chk("eng_start", eng_start, 1'b1);
            chk("ready_busy", {req1_ready, req0_ready}, 2'b00);
            chk("eng_zSig", eng_zSig, op_sig[win]);
            chk("eng_zSignExp", {eng_zSign, eng_zExp}, {op_sign[win], op_exp[win]});
            chk("eng_flag_i", eng_flag_i, m_flag[win]);
            eng_done       = (c == lat);
            eng_return     = (c == lat) ? ret : {$urandom, $urandom};
            eng_flag_o_vld = (c == fcyc);
            eng_flag_o     = fval;
            flag_clr       = (c == ccyc) ? cmask : 2'b00;
            @(posedge ap_clk);
            if (c == fcyc) m_flag[win] = fval;
            for (int n = 0; n < 2; n++)
                if (c == ccyc && cmask[n] && !(c == fcyc && n == win)) m_flag[n] = 32'd0;
            #1;
            eng_done       = 1'b0;
            eng_flag_o_vld = 1'b0;
            flag_clr       = 2'b00;
            if (c == lat) break;
        end
        aborted  = (lat > WDOG);
        exp_data = aborted ? NANV : ret;
        if (aborted) m_wdog = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("resp_eng_start", eng_start, 1'b0);
        chk("resp_valid", {resp1_valid, resp0_valid}, (win == 1) ? 2'b10 : 2'b01);
        chk("resp_data", resp_data, exp_data);
        chk("resp_err", resp_err, aborted);
        chk("wdog_err", wdog_err, m_wdog);
        chk("flag0", flag0, m_flag[0]);
        chk("flag1", flag1, m_flag[1]);
        // stall; the wrong channel's ready must not complete the response
        for (int h = 0; h < hold; h++) begin
            if (win == 0) resp1_ready = 1'b1;
            else          resp0_ready = 1'b1;
            step();
            chk("hold_valid", {resp1_valid, resp0_valid}, (win == 1) ? 2'b10 : 2'b01);
            chk("hold_data", {63'd0, resp_err} ^ resp_data, {63'd0, 1'(aborted)} ^ exp_data);
        end
        resp0_ready = (win == 0);
        resp1_ready = (win == 1);
        step();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chk("post_resp_valid", {resp1_valid, resp0_valid}, 2'b00);
        chk("post_resp_err", resp_err, 1'b0);
        chk("post_eng_start", eng_start, 1'b0);
    endtask

    initial begin
        ap_rst = 1'b1;
        req0_valid = 1'b0; req0_sign = 1'b0; req0_exp = 12'd0; req0_sig = 64'd0;
        req1_valid = 1'b0; req1_sign = 1'b0; req1_exp = 12'd0; req1_sig = 64'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0; flag_clr = 2'b00;
        eng_done = 1'b0; eng_flag_o = 32'd0; eng_flag_o_vld = 1'b0; eng_return = 64'd0;
        model_reset();
        #2;
        chk_all_zero("reset");
        step();
        step();
        ap_rst = 1'b0;
        step();

        // tie after reset: req0, req1, req0 with minimum spacing
        for (int j = 0; j < 3; j++) begin
            rand_ops();
            run_job(2'b11, 3, {$urandom, $urandom}, 0, 32'd0, 0, 2'b00, 0);
        end

        // directed operand/result pairs
        op_sign[0] = 1'b0; op_exp[0] = 12'h3FF; op_sig[0] = 64'h4000000000000000;
        run_job(2'b01, 3, 64'h4000000000000000, 0, 32'd0, 0, 2'b00, 1);
        op_sign[1] = 1'b1; op_exp[1] = 12'h7FE; op_sig[1] = 64'hFFFFFFFFFFFFFFFF;
        run_job(2'b10, 4, 64'hFFF0000000000000, 4, FLAG_OVERFLOW | FLAG_INEXACT, 0, 2'b00, 0);

        // update beats coincident clear on requester 0; requester 1 clear still applies
        rand_ops();
        run_job(2'b01, 4, {$urandom, $urandom}, 2, FLAG_INEXACT, 2, 2'b11, 0);

        // engine done exactly on the last allowed cycle still wins over the watchdog
        rand_ops();
        run_job(2'b10, WDOG, {$urandom, $urandom}, 0, 32'd0, 0, 2'b00, 0);

        // engine never finishes: watchdog abort
        rand_ops();
        run_job(2'b01, 1000, {$urandom, $urandom}, 0, 32'd0, 0, 2'b00, 2);

        // engine done while idle is ignored
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("idle_done_start", eng_start, 1'b0);
        chk("idle_done_resp", {resp1_valid, resp0_valid}, 2'b00);

        // flag clear while idle
        flag_clr = 2'b11;
        step();
        flag_clr = 2'b00;
        m_flag[0] = 32'd0;
        m_flag[1] = 32'd0;
        chk("idle_clr", {flag1, flag0}, 64'd0);

        // randomized jobs
        for (int j = 0; j < 20; j++) begin
            logic [1:0] vm;
            int         lat;
            rand_ops();
            vm  = 2'($urandom_range(1, 3));
            lat = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(3, 5));
            run_job(vm, lat, {$urandom, $urandom}, int'($urandom_range(0, 4)), $urandom,
                    int'($urandom_range(0, 4)), 2'($urandom), int'($urandom_range(0, 2)));
        end

        // reset in the middle of RUN: start drops at once, no response, clean restart
        rand_ops();
        req0_sign = op_sign[0]; req0_exp = op_exp[0]; req0_sig = op_sig[0];
        req0_valid = 1'b1;
        step();
        step();
        chk("mid_run_start", eng_start, 1'b1);
        #1;
        ap_rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        step();
        ap_rst = 1'b0;
        req0_valid = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_resp_after_rst", {resp1_valid, resp0_valid, eng_start}, 3'b000);
        end
        rand_ops();
        run_job(2'b11, 3, {$urandom, $urandom}, 3, FLAG_UNDERFLOW, 0, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_pack_sched.md
ROUND_PACK_SCHED -- requirements
Module: round_pack_sched

Interface
REQ-001 The block SHALL have parameter WDOG_CYC, default 16, giving the maximum engine cycles allowed per job before abort.
REQ-002 The block SHALL have parameter NAN_RESULT, default 64'h7FF8000000000000, giving the result returned on watchdog abort.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed first in REQ-004 and REQ-005.
REQ-004 ap_clk  in  1  clock.
REQ-005 ap_rst  in  1  reset, asynchronous, active-high.
REQ-006 reqN_valid / reqN_ready  in / out  1 each  request handshake, N = 0, 1.
REQ-007 reqN_sign / reqN_exp / reqN_sig  in  1 / 12 / 64  request operands.
REQ-008 respN_valid / respN_ready  out / in  1 each  response handshake.
REQ-009 resp_data  out  64  packed double result, shared by both response channels.
REQ-010 resp_err  out  1  the current response was a watchdog abort.
REQ-011 flagN  out  32  sticky exception flags for requester N.
REQ-012 flag_clr  in  2  per-requester flag clear.
REQ-013 wdog_err  out  1  sticky watchdog error flag.
REQ-014 eng_start  out  1  engine start (ap_ctrl_hs).
REQ-015 eng_done  in  1  engine done.
REQ-016 eng_zSign / eng_zExp / eng_zSig  out  1 / 12 / 64  engine operands.
REQ-017 eng_flag_i  out  32  engine flag input; eng_flag_o / eng_flag_o_vld  in  32 / 1  engine flag output.
REQ-018 eng_return  in  64  engine result.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, RESP, and SHALL occupy exactly one at a time.
REQ-020 In IDLE, reqN_ready SHALL be 1 only for the granted requester; reqN_ready SHALL be 0 in RUN and RESP.
REQ-021 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins.
REQ-022 Reset SHALL set the last-grant pointer to 1, so req0 wins the first tie.
REQ-023 On accept (valid & ready), the block SHALL capture operands and requester id, update the pointer, and go to RUN next cycle.
REQ-024 In RUN, eng_start SHALL be 1, eng_z* SHALL be driven from the captured registers, and they SHALL stay stable until eng_done.
REQ-025 eng_done SHALL be honoured only while eng_start=1; the engine's idle done (start=0) SHALL be ignored.
REQ-026 On eng_done in RUN, the block SHALL capture eng_return and go to RESP; eng_start SHALL be 0 from the next cycle.
REQ-027 eng_flag_i SHALL equal flagN of the active requester.
REQ-028 When eng_flag_o_vld=1 in RUN, flagN of the active requester SHALL be loaded with eng_flag_o.
REQ-029 If a clear and a flag update hit the same flag register in one cycle, the update SHALL win and the clear SHALL be dropped.
REQ-030 A flag_clr bit SHALL otherwise zero its flag register on the next edge.
REQ-031 An RUN cycle counter SHALL count from 1; on reaching WDOG_CYC without eng_done, the block SHALL load NAN_RESULT, set resp_err=1, set wdog_err, and go to RESP.
REQ-032 In RESP, respN_valid SHALL be 1 only for the active requester, with resp_data and resp_err held.
REQ-033 On respN_ready in RESP, the block SHALL go to IDLE and clear resp_err.
REQ-034 Timing: accept at cycle 0, eng_start at 1..k where k = 3 or 4 is the engine done cycle, respN_valid at k+1; minimum accept-to-accept is 5 cycles.
REQ-035 reqN_valid deasserting while the block is busy SHALL have no effect on the accepted job.

Reset
REQ-036 Reset SHALL force IDLE and clear every output to 0: eng_start, all ready/valid, resp_data, resp_err, flag0, flag1, wdog_err.
REQ-037 Reset asserted mid-job SHALL abandon the job with no response; eng_start SHALL drop immediately (asynchronously).

Structure
REQ-038 The shared package SHALL hold the FSM state enum, the NAN_RESULT default, and the flag bit constants (inexact=1, underflow=4, overflow=8).
REQ-039 The block SHALL have one sub-module, rr_arb2: the 2-way round-robin grant with pointer.
REQ-040 The roundAndPackFloat64 instance SHALL sit outside this block, in the parent.

Verification
REQ-041 req0 {0, 0x3FF, 0x4000000000000000} -> resp0 data 0x4000000000000000, flag0 = 0.
REQ-042 req1 {1, 0x7FE, 0xFFFFFFFFFFFFFFFF} -> resp1 data 0xFFF0000000000000, flag1 = 0x9.
REQ-043 Both valid, same cycle, after reset -> order req0, req1, req0, …; accepts at least 5 cycles apart.
REQ-044 eng_done stuck 0 -> at RUN cycle 16: resp data 0x7FF8000000000000, resp_err=1, wdog_err=1.
REQ-045 flag_clr[0] coincident with eng_flag_o_vld=1 (0x1) on requester 0 -> flag0 = 0x1.
REQ-046 ap_rst pulse during RUN -> no resp, eng_start=0 asynchronously, a new job completes normally.
